// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer-width helper and read-mode constants for fifo_flags.
package fifo_pkg;
  localparam int FWFT_SHOWAHEAD = 1;
  localparam int FWFT_REGISTERED = 0;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH simple dual-port array, synchronous write, asynchronous read.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fifo_flags.sv
// fifo_flags: synchronous FIFO with programmable thresholds, fill count, sticky
// error flags, flush and selectable show-ahead / registered read.
module fifo_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   rd_en,
  input  logic                   flush,
  input  logic                   clr_err,
  output logic [WIDTH-1:0]       data_out,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C = PW'(AE_THRESH);
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic ovf_q, ovf_d, unf_q, unf_d, rd_valid_q, rd_valid_d, wr_ok, rd_ok;
  logic [WIDTH-1:0] dout_q, dout_d, rdata;
  // Extra wrap bit makes the pointer difference the exact occupancy 0..DEPTH.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign full         = count == DEPTH_C;
  assign empty        = count == '0;
  assign almost_full  = count >= AF_C;
  assign almost_empty = count <= AE_C;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign rd_valid     = (FWFT == FWFT_SHOWAHEAD) ? !empty : rd_valid_q;
  assign data_out     = (FWFT == FWFT_SHOWAHEAD) ? (empty ? '0 : rdata) : dout_q;
  fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rdata)
  );
  always_comb begin
    wr_ok      = rst_n && wr_en && !full && !flush;
    rd_ok      = rd_en && !empty && !flush;
    wr_ptr_d   = flush ? '0 : wr_ptr_q + PW'(wr_ok);
    rd_ptr_d   = flush ? '0 : rd_ptr_q + PW'(rd_ok);
    ovf_d      = (wr_en && full && !flush) || (ovf_q && !clr_err);
    unf_d      = (rd_en && empty && !flush) || (unf_q && !clr_err);
    rd_valid_d = (FWFT == FWFT_REGISTERED) && rd_ok;
    dout_d     = rd_ok ? rdata : dout_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_valid_q <= rd_valid_d;
      dout_q     <= dout_d;
    end
  end
endmodule

// File: tb/tb_fifo_flags.sv
// tb_fifo_flags: directed vectors for fifo_flags, show-ahead and registered-read
// instances driven from the same stimulus.
module tb_fifo_flags;
  logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0, clr_err = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] a_dout, b_dout;
  logic [4:0] a_cnt, b_cnt;
  logic a_rv, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic b_rv, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  fifo_flags u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .flush(flush), .clr_err(clr_err), .data_out(a_dout), .rd_valid(a_rv),
    .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
    .count(a_cnt), .overflow(a_ovf), .underflow(a_unf)
  );

  fifo_flags #(.FWFT(0)) u_reg (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .flush(flush), .clr_err(clr_err), .data_out(b_dout), .rd_valid(b_rv),
    .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
    .count(b_cnt), .overflow(b_ovf), .underflow(b_unf)
  );

  typedef struct {
    bit rst_n, wr, rd, fl, clr;
    logic [7:0] din;
    int cnt;
    bit ovf, unf;
    logic [7:0] dout;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit w, bit rd, bit fl, bit clr, logic [7:0] din,
                              int cnt, bit ovf, bit unf, logic [7:0] dout);
    vec_t v;
    v.rst_n = r; v.wr = w; v.rd = rd; v.fl = fl; v.clr = clr; v.din = din;
    v.cnt = cnt; v.ovf = ovf; v.unf = unf; v.dout = dout;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit r, bit w, bit rd, bit fl, bit clr, logic [7:0] din);
    rst_n = r; wr_en = w; rd_en = rd; flush = fl; clr_err = clr; data_in = din;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] popped;
    int written, k;
    bit up, w, r, was_rd;

    vecs.push_back(mk(0,0,0,0,0,8'h00, 0,0,0,8'h00));
    for (int i = 0; i < 16; i++) vecs.push_back(mk(1,1,0,0,0,8'(i+1), i+1,0,0,8'h01));
    vecs.push_back(mk(1,1,0,0,0,8'h55, 16,1,0,8'h01));
    for (int i = 0; i < 16; i++) vecs.push_back(mk(1,0,1,0,0,8'h00, 15-i,1,0, i==15 ? 8'h00 : 8'(i+2)));
    vecs.push_back(mk(1,0,1,0,0,8'h00, 0,1,1,8'h00));
    vecs.push_back(mk(1,0,0,0,1,8'h00, 0,0,0,8'h00));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1,1,0,0,0,8'(8'h21+i), i+1,0,0,8'h21));
    vecs.push_back(mk(1,1,1,0,0,8'h26, 5,0,0,8'h22));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1,0,1,0,0,8'h00, 4-i,0,0,8'(8'h23+i)));
    vecs.push_back(mk(1,0,1,0,0,8'h00, 0,0,0,8'h00));
    vecs.push_back(mk(1,1,1,0,0,8'h31, 1,0,1,8'h31));
    vecs.push_back(mk(1,0,0,0,1,8'h00, 1,0,0,8'h31));
    for (int i = 0; i < 15; i++) vecs.push_back(mk(1,1,0,0,0,8'(8'h32+i), i+2,0,0,8'h31));
    vecs.push_back(mk(1,1,1,0,0,8'h77, 15,1,0,8'h32));
    for (int i = 0; i < 6; i++) vecs.push_back(mk(1,0,1,0,0,8'h00, 14-i,1,0,8'(8'h33+i)));
    vecs.push_back(mk(1,1,0,1,0,8'h99, 0,1,0,8'h00));
    vecs.push_back(mk(1,0,1,1,0,8'h00, 0,1,0,8'h00));
    vecs.push_back(mk(1,1,0,0,0,8'hAB, 1,1,0,8'hAB));
    for (int i = 0; i < 6; i++) vecs.push_back(mk(1,1,0,0,0,8'(8'hB0+i), i+2,1,0,8'hAB));
    vecs.push_back(mk(0,1,1,0,0,8'hCC, 0,0,0,8'h00));
    vecs.push_back(mk(1,0,1,0,1,8'h00, 0,0,1,8'h00));
    vecs.push_back(mk(1,0,0,0,1,8'h00, 0,0,0,8'h00));

    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].wr, vecs[i].rd, vecs[i].fl, vecs[i].clr, vecs[i].din);
      step();
      chk("count", i, a_cnt, vecs[i].cnt);
      chk("full", i, a_full, vecs[i].cnt == 16);
      chk("empty", i, a_empty, vecs[i].cnt == 0);
      chk("almost_full", i, a_af, vecs[i].cnt >= 14);
      chk("almost_empty", i, a_ae, vecs[i].cnt <= 2);
      chk("overflow", i, a_ovf, vecs[i].ovf);
      chk("underflow", i, a_unf, vecs[i].unf);
      chk("data_out", i, a_dout, vecs[i].dout);
      chk("rd_valid", i, a_rv, vecs[i].cnt != 0);
      chk("reg_count", i, b_cnt, vecs[i].cnt);
    end

    // Registered-read latency and hold; FIFO is empty with clean flags here.
    chk("reg_dout_reset", 0, b_dout, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive(1,1,0,0,0,8'(8'hA1+i));
      step();
      chk("reg_rv_idle", i, b_rv, 0);
    end
    drive(1,0,1,0,0,8'h00);
    step();
    chk("reg_rv_read", 0, b_rv, 1);
    chk("reg_dout_read", 0, b_dout, 8'hA1);
    chk("fwft_head", 0, a_dout, 8'hA2);
    drive(1,0,0,0,0,8'h00);
    step();
    chk("reg_rv_hold", 0, b_rv, 0);
    chk("reg_dout_hold", 0, b_dout, 8'hA1);
    drive(1,0,1,1,0,8'h00);
    step();
    chk("reg_rv_flush", 0, b_rv, 0);
    chk("reg_dout_flush", 0, b_dout, 8'hA1);
    chk("flush_count", 0, b_cnt, 0);
    chk("flush_unf", 0, b_unf, 0);

    // Wrap: occupancy oscillates 3..12 against a queue model.
    written = 0; k = 0; up = 1;
    while ((written < 60 || q.size() > 0) && k < 1000) begin
      if (written >= 60) begin w = 0; r = 1; end
      else if (up) begin w = 1; r = (k % 4 == 3) && q.size() > 0; end
      else begin r = 1; w = (k % 4 == 3); end
      was_rd = r && q.size() > 0;
      popped = was_rd ? q[0] : 8'h00;
      drive(1, w, r, 0, 0, 8'(8'h40 + written));
      step();
      if (w) begin q.push_back(8'(8'h40 + written)); written++; end
      if (was_rd) void'(q.pop_front());
      chk("wrap_count", k, a_cnt, q.size());
      chk("wrap_head", k, a_dout, q.size() > 0 ? q[0] : 8'h00);
      chk("wrap_reg_rv", k, b_rv, was_rd);
      if (was_rd) chk("wrap_reg_dout", k, b_dout, popped);
      if (q.size() >= 12) up = 0;
      else if (q.size() <= 3) up = 1;
      k++;
    end
    drive(1,0,0,0,0,8'h00);
    if (k >= 1000) begin
      errs++;
      $display("FAIL wrap_timeout: got %0d cycles expected fewer than 1000", k);
    end
    chk("wrap_written", 0, written, 60);
    chk("wrap_flags", 0, {a_ovf, a_unf}, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
